// File: rtl/sorted_dedup_if.sv
// Stream handshake bundle for sorted_dedup: sink side in, source side out,
// plus the per-packet duplicate count and framing error flag.
interface sorted_dedup_if #(
    parameter int DWIDTH = 64,
    parameter int CWIDTH = 7
);
    logic [DWIDTH-1:0] snk_data_i;
    logic              snk_startofpacket_i;
    logic              snk_endofpacket_i;
    logic              snk_valid_i;
    logic              snk_ready_o;
    logic [DWIDTH-1:0] src_data_o;
    logic              src_startofpacket_o;
    logic              src_endofpacket_o;
    logic              src_valid_o;
    logic              src_ready_i;
    logic [CWIDTH-1:0] dup_cnt_o;
    logic              err_o;

    modport slave (
        input  snk_data_i, snk_startofpacket_i, snk_endofpacket_i,
        input  snk_valid_i, src_ready_i,
        output snk_ready_o, src_data_o, src_startofpacket_o,
        output src_endofpacket_o, src_valid_o, dup_cnt_o, err_o
    );

    modport master (
        output snk_data_i, snk_startofpacket_i, snk_endofpacket_i,
        output snk_valid_i, src_ready_i,
        input  snk_ready_o, src_data_o, src_startofpacket_o,
        input  src_endofpacket_o, src_valid_o, dup_cnt_o, err_o
    );
endinterface

// File: rtl/sorted_dedup.sv
// Drops adjacent repeated words from sorted packets, counting discards.
// Define SORTED_DEDUP_FRAMING_CHECK_EN to compile in the sticky framing check.
module sorted_dedup #(
    parameter int DWIDTH      = 64,
    parameter int MAX_PKT_LEN = 128,
    localparam int CWIDTH     = $clog2(MAX_PKT_LEN)
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    sorted_dedup_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FLUSH
    } state_t;

    state_t            state;
    logic [DWIDTH-1:0] hold_q;
    logic              hold_sop_q;
    logic [CWIDTH-1:0] cnt_q;

    logic [DWIDTH-1:0] out_data_q;
    logic              out_sop_q;
    logic              out_eop_q;
    logic              out_valid_q;
    logic [CWIDTH-1:0] out_dup_q;

    logic out_free;
    logic snk_ready;
    logic acc;
    logic same;

    assign out_free  = !out_valid_q || bus.src_ready_i;
    // Gated by reset so the sink sees not-ready while reset is held.
    assign snk_ready = arst_n_i &&
                       ((state == IDLE) || (state == HOLD && out_free));
    assign acc       = bus.snk_valid_i && snk_ready;
    assign same      = (bus.snk_data_i == hold_q);

    assign bus.snk_ready_o         = snk_ready;
    assign bus.src_data_o          = out_data_q;
    assign bus.src_startofpacket_o = out_sop_q;
    assign bus.src_endofpacket_o   = out_eop_q;
    assign bus.src_valid_o         = out_valid_q;
    assign bus.dup_cnt_o           = out_dup_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state       <= IDLE;
            hold_q      <= '0;
            hold_sop_q  <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_dup_q   <= '0;
        end else begin
            // Drained beat frees the register; a load below overrides this.
            if (bus.src_ready_i) out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc && bus.snk_startofpacket_i) begin
                        hold_q     <= bus.snk_data_i;
                        hold_sop_q <= 1'b1;
                        cnt_q      <= '0;
                        state      <= bus.snk_endofpacket_i ? FLUSH : HOLD;
                    end
                end
                HOLD: begin
                    if (acc) begin
                        if (same) begin
                            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        end else begin
                            out_data_q  <= hold_q;
                            out_sop_q   <= hold_sop_q;
                            out_eop_q   <= 1'b0;
                            out_dup_q   <= '0;
                            out_valid_q <= 1'b1;
                            hold_q      <= bus.snk_data_i;
                            hold_sop_q  <= 1'b0;
                        end
                        if (bus.snk_endofpacket_i) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        out_data_q  <= hold_q;
                        out_sop_q   <= hold_sop_q;
                        out_eop_q   <= 1'b1;
                        out_dup_q   <= cnt_q;
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SORTED_DEDUP_FRAMING_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            err_q <= 1'b0;
        end else if (acc) begin
            if (state == IDLE && !bus.snk_startofpacket_i) err_q <= 1'b1;
            if (state == HOLD && bus.snk_startofpacket_i) err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_sorted_dedup.sv
// Directed bench for sorted_dedup: packet table plus stall, reset and
// framing sequences, checked against hand-computed outputs.
module tb_sorted_dedup;
    localparam int DW = 64;
    localparam int CW = 7;

`ifdef SORTED_DEDUP_FRAMING_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk;
    logic arst_n;

    sorted_dedup_if #(.DWIDTH(DW), .CWIDTH(CW)) ifc ();

    sorted_dedup #(.DWIDTH(DW), .MAX_PKT_LEN(128)) dut (
        .clk_i   (clk),
        .arst_n_i(arst_n),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]           n_in;
        logic [0:7][DW-1:0]   din;
        logic [3:0]           n_out;
        logic [0:7][DW-1:0]   dout;
        logic [CW-1:0]        dup;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
        logic [CW-1:0] dup;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (arst_n && ifc.src_valid_o && ifc.src_ready_i)
            q.push_back('{ifc.src_data_o, ifc.src_startofpacket_o,
                          ifc.src_endofpacket_o, ifc.dup_cnt_o});
    end

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic s,
                             input logic e);
        bit done;
        done = 0;
        ifc.snk_data_i          = d;
        ifc.snk_startofpacket_i = s;
        ifc.snk_endofpacket_i   = e;
        ifc.snk_valid_i         = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (ifc.snk_ready_o) done = 1;
            @(posedge clk);
            #1;
        end
        ifc.snk_valid_i         = 1'b0;
        ifc.snk_startofpacket_i = 1'b0;
        ifc.snk_endofpacket_i   = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_beat: timeout on data %0h", d);
        end
    endtask

    task automatic send_pkt(input vec_t v);
        for (int i = 0; i < int'(v.n_in); i++)
            send_beat(v.din[i], i == 0, i == int'(v.n_in) - 1);
    endtask

    task automatic check_out(input string nm, input vec_t v);
        chk({nm, " count"}, DW'(q.size()), DW'(v.n_out));
        for (int i = 0; i < int'(v.n_out) && i < q.size(); i++) begin
            chk({nm, " data"}, q[i].d, v.dout[i]);
            chk({nm, " sop"}, DW'(q[i].s), DW'(i == 0));
            chk({nm, " eop"}, DW'(q[i].e), DW'(i == int'(v.n_out) - 1));
            if (i == int'(v.n_out) - 1)
                chk({nm, " dup"}, DW'(q[i].dup), DW'(v.dup));
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        q.delete();
        send_pkt(v);
        repeat (5) @(posedge clk);
        #1;
        check_out(nm, v);
    endtask

    vec_t vecs[6];
    vec_t v_stall;
    vec_t v_nine;
    vec_t v_six;
    bit   saw_low;

    initial begin
        localparam logic [DW-1:0] A = 64'h0123_4567_89ab_cdef;
        localparam logic [DW-1:0] B = 64'h8123_4567_89ab_cdef;

        vecs[0] = '{4'd6, '{1, 1, 2, 3, 3, 3, 0, 0},
                    4'd3, '{1, 2, 3, 0, 0, 0, 0, 0}, 7'd3};
        vecs[1] = '{4'd1, '{7, 0, 0, 0, 0, 0, 0, 0},
                    4'd1, '{7, 0, 0, 0, 0, 0, 0, 0}, 7'd0};
        vecs[2] = '{4'd4, '{5, 5, 5, 5, 0, 0, 0, 0},
                    4'd1, '{5, 0, 0, 0, 0, 0, 0, 0}, 7'd3};
        vecs[3] = '{4'd4, '{1, 2, 1, 2, 0, 0, 0, 0},
                    4'd4, '{1, 2, 1, 2, 0, 0, 0, 0}, 7'd0};
        vecs[4] = '{4'd3, '{A, B, B, 0, 0, 0, 0, 0},
                    4'd2, '{A, B, 0, 0, 0, 0, 0, 0}, 7'd1};
        vecs[5] = '{4'd2, '{9, 9, 0, 0, 0, 0, 0, 0},
                    4'd1, '{9, 0, 0, 0, 0, 0, 0, 0}, 7'd1};
        v_stall = '{4'd4, '{1, 2, 3, 4, 0, 0, 0, 0},
                    4'd4, '{1, 2, 3, 4, 0, 0, 0, 0}, 7'd0};
        v_nine  = '{4'd1, '{9, 0, 0, 0, 0, 0, 0, 0},
                    4'd1, '{9, 0, 0, 0, 0, 0, 0, 0}, 7'd0};
        v_six   = '{4'd1, '{6, 0, 0, 0, 0, 0, 0, 0},
                    4'd1, '{6, 0, 0, 0, 0, 0, 0, 0}, 7'd0};

        arst_n                  = 1'b0;
        ifc.snk_data_i          = '0;
        ifc.snk_startofpacket_i = 1'b0;
        ifc.snk_endofpacket_i   = 1'b0;
        ifc.snk_valid_i         = 1'b0;
        ifc.src_ready_i         = 1'b1;

        #3;
        chk("rst src_valid", DW'(ifc.src_valid_o), 0);
        chk("rst src_sop", DW'(ifc.src_startofpacket_o), 0);
        chk("rst src_eop", DW'(ifc.src_endofpacket_o), 0);
        chk("rst src_data", ifc.src_data_o, 0);
        chk("rst dup", DW'(ifc.dup_cnt_o), 0);
        chk("rst err", DW'(ifc.err_o), 0);
        chk("rst snk_ready", DW'(ifc.snk_ready_o), 0);

        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst snk_ready", DW'(ifc.snk_ready_o), 1);

        for (int i = 0; i < 6; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);
        chk("idle snk_ready", DW'(ifc.snk_ready_o), 1);
        chk("no err", DW'(ifc.err_o), 0);

        // Output backpressure for three cycles after the first source beat.
        q.delete();
        saw_low = 0;
        fork
            send_pkt(v_stall);
            begin
                bit seen;
                seen = 0;
                for (int t = 0; t < 30 && !seen; t++) begin
                    @(negedge clk);
                    if (ifc.src_valid_o) seen = 1;
                end
                @(posedge clk);
                #1;
                ifc.src_ready_i = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (!ifc.snk_ready_o) saw_low = 1;
                end
                @(posedge clk);
                #1;
                ifc.src_ready_i = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("stall snk_ready low", DW'(saw_low), 1);
        check_out("stall", v_stall);

        // Reset with a word in the output register and one held.
        q.delete();
        ifc.src_ready_i = 1'b0;
        send_beat(1, 1'b1, 1'b0);
        send_beat(2, 1'b0, 1'b0);
        chk("pre-rst src_valid", DW'(ifc.src_valid_o), 1);
        ifc.snk_data_i  = 3;
        ifc.snk_valid_i = 1'b1;
        #2;
        arst_n = 1'b0;
        #1;
        chk("mid-rst src_valid", DW'(ifc.src_valid_o), 0);
        chk("mid-rst src_data", ifc.src_data_o, 0);
        chk("mid-rst src_sop", DW'(ifc.src_startofpacket_o), 0);
        chk("mid-rst snk_ready", DW'(ifc.snk_ready_o), 0);
        ifc.snk_valid_i = 1'b0;
        ifc.src_ready_i = 1'b1;
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel snk_ready", DW'(ifc.snk_ready_o), 1);
        chk("rel src_valid", DW'(ifc.src_valid_o), 0);
        chk("rst emitted", DW'(q.size()), 0);
        run_vec("after-rst", v_nine);

        // Non-SOP beat while idle.
        q.delete();
        send_beat(4, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("stray emitted", DW'(q.size()), 0);
        chk("stray err", DW'(ifc.err_o), DW'(EXP_ERR));
        run_vec("after-stray", v_six);
        chk("err sticky", DW'(ifc.err_o), DW'(EXP_ERR));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
